serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial front end that produces the serial bit stream `x` consumed by the downstream sequence-detecting state machine.
- Accepts a WIDTH-bit word through a load/ready handshake.
- Shifts the word out MSB-first, one bit per clock, with a qualifying valid flag.
- Pulses `done` on the last bit of each frame so the control logic can schedule the next word.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- load  input  1  request to accept data_in; honoured only while ready=1.
- data_in  input  WIDTH  parallel word to serialise; sampled on the accepting edge only.
- ready  output  1  high when a new word can be accepted.
- x  output  1  serial data bit to the downstream state machine.
- x_valid  output  1  high while x carries a frame bit.
- done  output  1  one-cycle pulse coincident with the final bit of a frame.

Behaviour:
- Reset: while reset=0 at a rising edge, the block returns to the following values after that edge:
  - state=IDLE, shift register=0, bit counter=0.
  - x=0, x_valid=0, done=0.
  - ready=0 while reset is low. ready is decoded as (state==IDLE) && reset.
- Reset mid-frame: the frame is aborted. x and x_valid are 0 from the next cycle. No done pulse is issued. Partial data is discarded.
- States:
  - IDLE: ready=1, x=0, x_valid=0. If load=1 at an edge, capture data_in and go to SHIFT.
  - SHIFT: emit bits; the counter counts down from WIDTH-1.
  - PARITY: exists only with the optional feature.
- Latency: load accepted at edge k.
  - From edge k: x=data_in[WIDTH-1], x_valid=1.
  - Bit i (MSB=0) is valid in the cycle after edge k+i.
  - The last data bit appears in the cycle after edge k+WIDTH-1, with done=1.
  - Return to IDLE at edge k+WIDTH; ready=1 from then.
- All outputs except ready are registered.
- Back-to-back frames: with load held high, consecutive frames are separated by exactly one idle cycle (x_valid=0).
- Load while busy (state≠IDLE): ignored. data_in is not captured and the current frame is unaffected.
- Load and reset together: reset wins; nothing is captured.
- WIDTH=1: single-bit frame. done is asserted together with the only bit.
- Bit counter width: $clog2(WIDTH+1). No wrap: the counter is reloaded on every accept.
- x must be 0 whenever x_valid=0.

Optional Feature:
- SERIAL_PARITY_EN:
  - Defined: after the last data bit, the block enters PARITY for one cycle. It drives x = even parity (XOR of all WIDTH captured bits) with x_valid=1.
  - done moves to the parity cycle, so a frame is WIDTH+1 bits and ready returns one cycle later.
- Undefined: the PARITY state and parity logic are absent. Frame length is WIDTH.

Decomposition:
- Shared package serial_pkg contains:
  - state typedef: IDLE, SHIFT, PARITY.
  - function cnt_w(width) returning $clog2(width+1).
  - localparam FRAME_LEN = WIDTH (+1 when SERIAL_PARITY_EN is defined).
- One natural sub-module: serial_bit_counter (loadable down-counter with terminal-count flag), used for the frame length.
- The FSM and shift register stay in serial_bit_feeder.

Test Plan:
- Reset then single frame: reset=0 for 2 cycles, then 1; load=1 for one cycle with data_in=8'hA5.
  - Expect x = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, x_valid=1 throughout.
  - Expect done=1 only on the 8th bit and ready=1 again on the next cycle.
- Load while busy: accept 8'hF0, then pulse load with 8'h0F at bit 3.
  - Expect the stream 1,1,1,1,0,0,0,0 unchanged and no second frame.
- Back-to-back: hold load=1, with data_in=8'hFF then 8'h00.
  - Expect 8 ones, one cycle with x_valid=0, then 8 zeros.
  - Expect done pulses 9 cycles apart.
- Mid-frame reset: accept 8'hAA; drive reset=0 at bit 4.
  - Expect x=0, x_valid=0, done never asserted, ready=1 the cycle after reset returns to 1.
- SERIAL_PARITY_EN defined: send 8'hA5 then 8'h07.
  - 8'hA5: expect 9-bit frames, parity bit 0, done on the 9th bit.
  - 8'h07: expect 9-bit frames, parity bit 1, done on the 9th bit.
- WIDTH=1 build: load data_in=1.
  - Expect a single-cycle frame with x=1, x_valid=1, done=1, and ready=1 on the next cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit feeder.
// Contents:
//   state_t      FSM state encoding (IDLE, SHIFT, PARITY)
//   PARITY_BITS  1 when SERIAL_PARITY_EN is defined, else 0
//   cnt_w()      bit-counter width for a given data width
//   frame_len()  number of serial bits per frame (data + optional parity)
//   even_parity() XOR reduction of a zero-extended word
// Configuration macro: SERIAL_PARITY_EN (appends an even-parity bit to each frame).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

`ifdef SERIAL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Zero-extension does not change the XOR, so any width up to 32 fits.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with terminal-count flag; tracks bits left in a frame.
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset (count -> 0)
//   i_load     load i_load_val (has priority over decrement)
//   i_load_val value to load
//   i_dec      decrement by one; holds at zero instead of wrapping
//   o_count    current count
//   o_tc       high when count is zero
module serial_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc    = (r_count == {CW{1'b0}});
  assign o_tc    = w_tc;
  assign o_count = r_count;

  // Count register: reset, reload on accept, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_tc) begin
      r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word on load&&ready and
// shifts it out MSB-first, one bit per clock, qualified by x_valid. done
// pulses with the final bit of the frame.
// Ports:
//   clk      system clock
//   reset    synchronous active-low reset
//   load     request to accept data_in (honoured only while ready=1)
//   data_in  word to serialise, sampled on the accepting edge
//   ready    high in IDLE while out of reset (combinational decode)
//   x        serial bit (0 whenever x_valid=0)
//   x_valid  high while x carries a frame bit
//   done     one-cycle pulse on the last bit of a frame
// Configuration macro: SERIAL_PARITY_EN -- appends one even-parity bit
// (PARITY state) after the data bits; done then moves to the parity bit.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CW        = cnt_w(WIDTH);
  localparam int FRAME_LEN = frame_len(WIDTH);
  // Counter holds "bits still to emit after the current one".
  localparam logic [CW-1:0] LOAD_VAL = CW'(FRAME_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_x, w_x_nxt;
  logic             r_x_valid, w_x_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             w_cnt_load, w_cnt_dec, w_cnt_tc;
  logic [CW-1:0]    w_cnt;
`ifdef SERIAL_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  serial_bit_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_tc       (w_cnt_tc)
  );

  assign ready   = (r_state == IDLE) && reset;
  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign done    = r_done;

  // Next-state and next-output decode; outputs are registered one edge later.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_x_nxt       = 1'b0;
    w_x_valid_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
`ifdef SERIAL_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (load) begin
          // MSB goes straight to x; the register keeps the remaining bits.
          w_state_nxt   = SHIFT;
          w_shift_nxt   = data_in << 1'b1;
          w_x_nxt       = data_in[WIDTH-1];
          w_x_valid_nxt = 1'b1;
          w_done_nxt    = (LOAD_VAL == {CW{1'b0}});
          w_cnt_load    = 1'b1;
`ifdef SERIAL_PARITY_EN
          w_parity_nxt  = even_parity(32'(data_in));
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_cnt_tc) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_dec     = 1'b1;
          w_x_valid_nxt = 1'b1;
          // Count of 1 means the bit about to be emitted is the last one.
          w_done_nxt    = (w_cnt == CW'(1));
`ifdef SERIAL_PARITY_EN
          if (w_cnt == CW'(1)) begin
            w_state_nxt = PARITY;
            w_x_nxt     = r_parity;
          end else begin
            w_x_nxt     = r_shift[WIDTH-1];
            w_shift_nxt = r_shift << 1'b1;
          end
`else
          w_x_nxt       = r_shift[WIDTH-1];
          w_shift_nxt   = r_shift << 1'b1;
`endif
        end
      end
      PARITY: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, shift register and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= {WIDTH{1'b0}};
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_x       <= w_x_nxt;
      r_x_valid <= w_x_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

`ifdef SERIAL_PARITY_EN
  // Parity of the captured word, presented after the last data bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

  localparam int W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  typedef struct packed {
    logic x;
    logic done;
  } bit_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready, x, x_valid, done;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .ready   (ready),
    .x       (x),
    .x_valid (x_valid),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of the serial bits still owed by the DUT.
  bit_t exp_q[$];
  bit   m_idle   = 1'b1;
  int   m_left   = 0;
  int   accepts  = 0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    bit_t b;
    for (int i = W - 1; i >= 0; i--) begin
      b.x    = d[i];
      b.done = (i == 0) && (F == W);
      exp_q.push_back(b);
    end
    if (F > W) begin
      b.x    = ^d;
      b.done = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Apply the spec rules for one rising edge with the inputs present at it.
  task automatic model_edge();
    if (!reset) begin
      exp_q.delete();
      m_idle = 1'b1;
      m_left = 0;
    end else if (m_idle) begin
      if (load) begin
        push_frame(data_in);
        m_idle = 1'b0;
        m_left = F;
        accepts++;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_idle = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic wait_accept(input int n);
    int t = 0;
    while (accepts == n && t < 50) begin
      step();
      t++;
    end
    chk("accept", accepts, n + 1);
  endtask

  // Monitor: compare DUT outputs against the model every falling edge.
  initial begin
    bit_t it;
    logic exp_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() != 0);
      chk("x_valid", x_valid, exp_v);
      chk("ready", ready, m_idle && reset);
      if (exp_v) begin
        it = exp_q.pop_front();
        chk("x", x, it.x);
        chk("done", done, it.done);
        if (done === 1'b1) done_cyc.push_back(cyc);
      end else begin
        chk("x_idle", x, 1'b0);
        chk("done_idle", done, 1'b0);
      end
    end
  end

  initial begin
    int n;
    // Reset for two edges, then single frame 8'hA5.
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    data_in = W'(8'hA5);
    load = 1'b1;
    n = accepts;
    wait_accept(n);
    load = 1'b0;
    repeat (F + 3) step();

    // Load while busy must be ignored.
    data_in = W'(8'hF0);
    load = 1'b1;
    n = accepts;
    wait_accept(n);
    load = 1'b0;
    repeat (3) step();
    data_in = W'(8'h0F);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (F + 3) step();

    // Back-to-back frames with load held high.
    done_cyc.delete();
    data_in = W'(8'hFF);
    load = 1'b1;
    n = accepts;
    wait_accept(n);
    data_in = W'(8'h00);
    wait_accept(n + 1);
    load = 1'b0;
    repeat (F + 3) step();
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_done_gap", done_cyc[1] - done_cyc[0], F + 1);

    // Mid-frame reset aborts the frame.
    data_in = W'(8'hAA);
    load = 1'b1;
    n = accepts;
    wait_accept(n);
    load = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (F + 2) step();

    // Randomised traffic with occasional resets.
    repeat (400) begin
      reset   = ($urandom_range(0, 59) != 0);
      load    = ($urandom_range(0, 2) != 0);
      data_in = W'($urandom);
      step();
    end
    reset = 1'b1;
    load  = 1'b0;
    repeat (F + 3) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
